// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port BRAM between two requesters with per-beat grant and tagged read return
// Ports: ACLK/ARESETN clock and async active-low reset; req_en/req_we/req_addr/req_wdata per-requester beat request
//   (slice i = requester i); req_gnt per-beat grant; req_rvalid/req_rdata tagged read return; mem_* BRAM side.
// Build option: FIXED_PRIO_EN gives requester 0 strict priority and removes round robin and the burst cap.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [1:0]              req_en,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              req_gnt,
  output logic [1:0]              req_rvalid,
  output logic [DATA_WIDTH-1:0]   req_rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);
  logic beat, win, rd;
  logic [RD_LATENCY-1:0] sr_v, sr_id;
  // gating with ARESETN keeps grants and BRAM strobes quiet for the whole reset window
  assign beat = ARESETN & |req_en;
`ifdef FIXED_PRIO_EN
  assign win = ~req_en[0];
`else
  localparam int CW = $clog2(MAX_BURST + 1);
  logic owner, owner_vld, last_owner, arb;
  logic [CW-1:0] burst_cnt;
  assign arb = owner_vld ? ((burst_cnt < CW'(MAX_BURST)) ? owner : ~owner) : ~last_owner;
  assign win = &req_en ? arb : req_en[1];
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      owner      <= 1'b0;
      owner_vld  <= 1'b0;
      last_owner <= 1'b1;
      burst_cnt  <= '0;
    end else if (beat) begin
      owner      <= win;
      owner_vld  <= 1'b1;
      last_owner <= win;
      burst_cnt  <= (owner_vld && owner == win)
                    ? ((burst_cnt == CW'(MAX_BURST)) ? burst_cnt : burst_cnt + CW'(1))
                    : CW'(1);
    end else begin
      owner_vld <= 1'b0;
      burst_cnt <= '0;
    end
`endif
  assign req_gnt   = beat ? {win, ~win} : 2'b00;
  assign mem_en    = beat;
  assign mem_we    = beat & (win ? req_we[1] : req_we[0]);
  assign mem_addr  = beat ? (win ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0]) : '0;
  assign mem_wdata = beat ? (win ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0]) : '0;
  assign rd        = beat & ~mem_we;
  // delay line of {valid, id} matching the BRAM read latency; last stage tags the returning data
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      sr_v  <= '0;
      sr_id <= '0;
    end else begin
      sr_v[0]  <= rd;
      sr_id[0] <= win;
      for (int i = 1; i < RD_LATENCY; i++) begin
        sr_v[i]  <= sr_v[i-1];
        sr_id[i] <= sr_id[i-1];
      end
    end
  assign req_rvalid = sr_v[RD_LATENCY-1] ? {sr_id[RD_LATENCY-1], ~sr_id[RD_LATENCY-1]} : 2'b00;
  assign req_rdata  = mem_rdata;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port local buffer BRAM (8-bit address, 32-bit data) between two requesters. Requester 0 is the AXI4-Lite sequencer's MEM port; requester 1 is the host-side loader/readback port. Sits between both requesters and the BRAM. Provides per-beat grant, round-robin fairness with a burst cap, and tagged read-data return that tracks the BRAM read latency.

Parameters:
ADDR_WIDTH, 8, BRAM address width
DATA_WIDTH, 32, BRAM data width
RD_LATENCY, 1, BRAM read latency in cycles; legal range 1..4
MAX_BURST, 16, max consecutive granted beats to one requester while the other waits; legal range >=1

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESETN  in  1  asynchronous active-low reset
req_en  in  2  bit i: requester i requests a beat this cycle
req_we  in  2  bit i: 1=write, 0=read
req_addr  in  2*ADDR_WIDTH  slice i = requester i address
req_wdata  in  2*DATA_WIDTH  slice i = requester i write data
req_gnt  out  2  bit i: requester i wins this cycle (combinational from req_en and state)
req_rvalid  out  2  bit i: req_rdata holds requester i read result this cycle
req_rdata  out  DATA_WIDTH  shared read data, equal to mem_rdata
mem_en  out  1  BRAM enable
mem_we  out  1  BRAM write enable
mem_addr  out  ADDR_WIDTH  BRAM address
mem_wdata  out  DATA_WIDTH  BRAM write data
mem_rdata  in  DATA_WIDTH  BRAM read data

Behaviour:
- A beat transfers when req_en[i] & req_gnt[i] are both high. At most one req_gnt bit is high per cycle. req_gnt[i] is never high while req_en[i] is low.
- A losing requester holds req_en/we/addr/wdata stable until it is granted.
- mem_en = OR(req_en & req_gnt). mem_we/mem_addr/mem_wdata are muxed from the winner in the same cycle (zero added latency). All are 0 when no beat.
- State: owner (1 bit), last_owner (1 bit), burst_cnt (clog2(MAX_BURST+1) bits), read-return shift register of RD_LATENCY entries {valid, id}.
- Winner selection:
  - Only one requesting: it wins.
  - Both requesting, and the owner has burst_cnt < MAX_BURST: the owner wins.
  - Both requesting, and the owner has burst_cnt == MAX_BURST: the other requester wins.
  - Both requesting, no current owner (previous cycle idle): ~last_owner wins.
- On each transfer: if the winner equals the previous winner, burst_cnt increments, saturating at MAX_BURST; otherwise burst_cnt=1 and owner=winner. last_owner=winner.
- Idle cycle (no beat): owner becomes invalid, burst_cnt=0. last_owner is kept.
- Read return: a read beat at cycle t produces req_rvalid[id]=1 for exactly one cycle at t+RD_LATENCY, with req_rdata=mem_rdata. Writes produce no rvalid. Back-to-back reads from alternating requesters return in issue order, one per cycle.
- Reset (async assert, sync release):
  - req_rvalid=0, burst_cnt=0, owner invalid, last_owner=1 (requester 0 wins first contention), shift register cleared.
  - mem_* and req_gnt are 0 while ARESETN low.
  - Reads in flight at reset are dropped and never return.

Optional Feature:
FIXED_PRIO_EN — when defined, requester 0 always wins contention. Burst cap, owner and last_owner logic are compiled out. Requester 1 is granted only when req_en[0]=0. When undefined, round-robin with burst cap as above.

Test Plan:
- After reset, req0 read addr 0x05, BRAM returns 0xDEADBEEF -> same cycle req_gnt=2'b01, mem_en=1, mem_we=0, mem_addr=0x05; next cycle req_rvalid=2'b01, req_rdata=0xDEADBEEF.
- req1 write addr 0x10 data 0x12345678 -> req_gnt=2'b10, mem_we=1, mem_addr=0x10, mem_wdata=0x12345678; req_rvalid stays 0.
- From reset, both req_en high, single beat each -> cycle0 gnt=01, cycle1 gnt=10.
- Both continuously requesting for 64 cycles, MAX_BURST=16 -> grants alternate in runs of exactly 16; mem_en high every cycle.
- RD_LATENCY=2, reads alternating req0 addr 0x01 / req1 addr 0x02 back-to-back -> rvalid 01 then 10 at +2 cycles, each with the matching data.
- ARESETN pulsed low one cycle after a read issue -> no rvalid ever appears. After release, contention grants req0 first. With FIXED_PRIO_EN, continuous contention grants req0 every cycle.
